// File: rtl/trigger_pulse_shaper.sv
`default_nettype none
// ============================================================================
// Module   : trigger_pulse_shaper
// Purpose  : Arms on a level, accepts a one-cycle trigger, and emits a delayed,
//            width-controlled pulse followed by a holdoff window. It also keeps
//            saturating counts of accepted and missed triggers.
// Revision : 1.0 - initial release
// ============================================================================
module trigger_pulse_shaper #(
    parameter int DLY_W = 32,
    parameter int PW_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_in,
    input  logic             arm,
    input  logic             oneshot,
    input  logic [DLY_W-1:0] delay,
    input  logic [PW_W-1:0]  pulse_width,
    input  logic [DLY_W-1:0] holdoff,
    input  logic             clear_cnt,
    output logic             trig_out,
    output logic             armed,
    output logic             busy,
    output logic [CNT_W-1:0] trig_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam logic [DLY_W-1:0] c_dly_one = DLY_W'(1);
    localparam logic [PW_W-1:0]  c_pw_one  = PW_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_PULSE   = 3'd3,
        S_HOLDOFF = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           r_state;
    logic [DLY_W-1:0] r_dly_cnt;
    logic [PW_W-1:0]  r_pw_cnt;
    logic [PW_W-1:0]  r_pw_lat;
    logic [DLY_W-1:0] r_hold_lat;
    logic             r_trig_out;
    logic             r_armed;
    logic             r_busy;
    logic [CNT_W-1:0] r_trig_count;
    logic [CNT_W-1:0] r_miss_count;

    state_t           w_next_state;
    state_t           w_resume_state;
    logic [DLY_W-1:0] w_dly_cnt_nxt;
    logic [PW_W-1:0]  w_pw_cnt_nxt;
    logic [PW_W-1:0]  w_pw_lat_nxt;
    logic [DLY_W-1:0] w_hold_lat_nxt;
    logic [PW_W-1:0]  w_pw_eff;
    logic             w_accept;
    logic             w_miss;
    logic             w_busy_nxt;
    logic [CNT_W-1:0] w_trig_count_nxt;
    logic [CNT_W-1:0] w_miss_count_nxt;

    // A zero width request still produces a one-cycle pulse.
    assign w_pw_eff       = (pulse_width == '0) ? c_pw_one : pulse_width;
    // oneshot is deliberately read at the moment the active window ends.
    assign w_resume_state = oneshot ? S_DONE : S_ARMED;

    always_comb begin
        w_next_state   = r_state;
        w_dly_cnt_nxt  = r_dly_cnt;
        w_pw_cnt_nxt   = r_pw_cnt;
        w_pw_lat_nxt   = r_pw_lat;
        w_hold_lat_nxt = r_hold_lat;
        w_accept       = 1'b0;
        w_miss         = trig_in && ((r_state == S_DELAY) || (r_state == S_PULSE) ||
                                     (r_state == S_HOLDOFF));

        if (!arm) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next_state = S_ARMED;
                end
                S_ARMED: begin
                    if (trig_in) begin
                        w_accept       = 1'b1;
                        w_pw_lat_nxt   = w_pw_eff;
                        w_hold_lat_nxt = holdoff;
                        if (delay != '0) begin
                            w_next_state  = S_DELAY;
                            w_dly_cnt_nxt = delay - c_dly_one;
                        end else begin
                            w_next_state = S_PULSE;
                            w_pw_cnt_nxt = w_pw_eff - c_pw_one;
                        end
                    end
                end
                S_DELAY: begin
                    if (r_dly_cnt == '0) begin
                        w_next_state = S_PULSE;
                        w_pw_cnt_nxt = r_pw_lat - c_pw_one;
                    end else begin
                        w_dly_cnt_nxt = r_dly_cnt - c_dly_one;
                    end
                end
                S_PULSE: begin
                    if (r_pw_cnt == '0) begin
                        if (r_hold_lat != '0) begin
                            w_next_state  = S_HOLDOFF;
                            w_dly_cnt_nxt = r_hold_lat - c_dly_one;
                        end else begin
                            w_next_state = w_resume_state;
                        end
                    end else begin
                        w_pw_cnt_nxt = r_pw_cnt - c_pw_one;
                    end
                end
                S_HOLDOFF: begin
                    if (r_dly_cnt == '0) begin
                        w_next_state = w_resume_state;
                    end else begin
                        w_dly_cnt_nxt = r_dly_cnt - c_dly_one;
                    end
                end
                S_DONE: begin
                    w_next_state = S_DONE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    assign w_busy_nxt = (w_next_state == S_DELAY) || (w_next_state == S_PULSE) ||
                        (w_next_state == S_HOLDOFF);

    // Clear has priority; otherwise counters stick at all-ones.
    always_comb begin
        w_trig_count_nxt = r_trig_count;
        w_miss_count_nxt = r_miss_count;
        if (clear_cnt) begin
            w_trig_count_nxt = '0;
            w_miss_count_nxt = '0;
        end else begin
            if (w_accept && !(&r_trig_count)) begin
                w_trig_count_nxt = r_trig_count + c_cnt_one;
            end
            if (w_miss && !(&r_miss_count)) begin
                w_miss_count_nxt = r_miss_count + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dly_cnt  <= '0;
            r_pw_cnt   <= '0;
            r_pw_lat   <= '0;
            r_hold_lat <= '0;
        end else begin
            r_state    <= w_next_state;
            r_dly_cnt  <= w_dly_cnt_nxt;
            r_pw_cnt   <= w_pw_cnt_nxt;
            r_pw_lat   <= w_pw_lat_nxt;
            r_hold_lat <= w_hold_lat_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_out   <= 1'b0;
            r_armed      <= 1'b0;
            r_busy       <= 1'b0;
            r_trig_count <= '0;
            r_miss_count <= '0;
        end else begin
            r_trig_out   <= (w_next_state == S_PULSE);
            r_armed      <= (w_next_state == S_ARMED);
            r_busy       <= w_busy_nxt;
            r_trig_count <= w_trig_count_nxt;
            r_miss_count <= w_miss_count_nxt;
        end
    end

    assign trig_out   = r_trig_out;
    assign armed      = r_armed;
    assign busy       = r_busy;
    assign trig_count = r_trig_count;
    assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_trigger_pulse_shaper.sv
`default_nettype none
// ============================================================================
// Module   : tb_trigger_pulse_shaper
// Purpose  : Scoreboard bench; an edge-indexed reference model predicts pulses
//            and status, and a monitor compares the DUT against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_pulse_shaper;

    localparam int DLY_W = 8;
    localparam int PW_W  = 4;
    localparam int CNT_W = 5;
    localparam int c_cnt_max = (1 << CNT_W) - 1;

    localparam int c_idle  = 0;
    localparam int c_armed = 1;
    localparam int c_busy  = 2;
    localparam int c_done  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             trig_in = 1'b0;
    logic             arm = 1'b0;
    logic             oneshot = 1'b0;
    logic [DLY_W-1:0] delay = '0;
    logic [PW_W-1:0]  pulse_width = '0;
    logic [DLY_W-1:0] holdoff = '0;
    logic             clear_cnt = 1'b0;
    logic             trig_out;
    logic             armed;
    logic             busy;
    logic [CNT_W-1:0] trig_count;
    logic [CNT_W-1:0] miss_count;

    trigger_pulse_shaper #(
        .DLY_W(DLY_W),
        .PW_W (PW_W),
        .CNT_W(CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .trig_in    (trig_in),
        .arm        (arm),
        .oneshot    (oneshot),
        .delay      (delay),
        .pulse_width(pulse_width),
        .holdoff    (holdoff),
        .clear_cnt  (clear_cnt),
        .trig_out   (trig_out),
        .armed      (armed),
        .busy       (busy),
        .trig_count (trig_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    // Reference model: pulse windows as absolute edge numbers.
    int m_mode  = c_idle;
    int m_start = 0;
    int m_w     = 0;
    int m_end   = 0;
    int m_trig  = 0;
    int m_miss  = 0;
    int q_start[$];
    int q_width[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        m_mode = c_idle;
        m_trig = 0;
        m_miss = 0;
        q_start.delete();
        q_width.delete();
    endtask

    task automatic model_edge();
        int  e;
        bit  acc;
        bit  mis;
        e   = edge_n;
        acc = 1'b0;
        mis = (m_mode == c_busy) && trig_in;
        if (!arm) begin
            if (m_mode == c_busy && q_start.size() > 0) begin
                if (e <= m_start) begin
                    q_start.delete(q_start.size() - 1);
                    q_width.delete(q_width.size() - 1);
                end else if (e < m_start + m_w) begin
                    q_width[q_width.size() - 1] = e - m_start;
                end
            end
            m_mode = c_idle;
        end else begin
            case (m_mode)
                c_idle:  m_mode = c_armed;
                c_armed: begin
                    if (trig_in) begin
                        acc     = 1'b1;
                        m_w     = (pulse_width == 0) ? 1 : int'(pulse_width);
                        m_start = e + int'(delay);
                        m_end   = m_start + m_w + int'(holdoff);
                        q_start.push_back(m_start);
                        q_width.push_back(m_w);
                        m_mode  = c_busy;
                    end
                end
                c_busy: begin
                    if (e == m_end) m_mode = oneshot ? c_done : c_armed;
                end
                default: m_mode = c_done;
            endcase
        end
        if (clear_cnt) begin
            m_trig = 0;
            m_miss = 0;
        end else begin
            if (acc && m_trig < c_cnt_max) m_trig++;
            if (mis && m_miss < c_cnt_max) m_miss++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        if (!rst) model_edge();
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fire();
        trig_in = 1'b1;
        step();
        trig_in = 1'b0;
    endtask

    task automatic set_cfg(input int d, input int w, input int h, input bit os);
        delay       = DLY_W'(d);
        pulse_width = PW_W'(w);
        holdoff     = DLY_W'(h);
        oneshot     = os;
    endtask

    // Monitor: pops one expected pulse per observed trig_out pulse.
    bit mon_in_pulse = 1'b0;
    int mon_start    = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mon_in_pulse = 1'b0;
            end else begin
                if (trig_out && !mon_in_pulse) begin
                    mon_in_pulse = 1'b1;
                    mon_start    = edge_n;
                    chk("pulse_expected", 64'(q_start.size() != 0), 64'd1);
                    if (q_start.size() != 0) chk("pulse_start", 64'(edge_n), 64'(q_start[0]));
                end else if (!trig_out && mon_in_pulse) begin
                    mon_in_pulse = 1'b0;
                    if (q_start.size() != 0) begin
                        chk("pulse_width", 64'(edge_n - mon_start), 64'(q_width[0]));
                        q_start.delete(0);
                        q_width.delete(0);
                    end
                end
                chk("armed", 64'(armed), 64'(m_mode == c_armed));
                chk("busy", 64'(busy), 64'(m_mode == c_busy));
                chk("trig_count", 64'(trig_count), 64'(m_trig));
                chk("miss_count", 64'(miss_count), 64'(m_miss));
            end
        end
    end

    int arm_low_left = 0;
    int saved_trig   = 0;

    initial begin
        // Reset acts before any clock edge.
        #2;
        chk("rst_trig_out", 64'(trig_out), 64'd0);
        chk("rst_armed", 64'(armed), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_trig_count", 64'(trig_count), 64'd0);
        chk("rst_miss_count", 64'(miss_count), 64'd0);
        steps(2);
        rst = 1'b0;
        model_reset();
        steps(3);

        // Trigger together with arm rising in IDLE is ignored.
        set_cfg(1, 1, 0, 1'b0);
        arm = 1'b1;
        fire();
        steps(4);
        chk("arm_rise_trig_ignored", 64'(trig_count), 64'd0);

        // delay=5 width=3 holdoff=0
        set_cfg(5, 3, 0, 1'b0);
        fire();
        steps(12);
        chk("basic_trig_count", 64'(trig_count), 64'd1);

        // delay=0 width=0 -> single-cycle pulse
        set_cfg(0, 0, 0, 1'b0);
        fire();
        steps(4);

        // Acceptance and misses around a holdoff window.
        set_cfg(2, 2, 4, 1'b0);
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        for (int k = 0; k < 10; k++) begin
            trig_in = (k == 0 || k == 3 || k == 8 || k == 9);
            step();
        end
        trig_in = 1'b0;
        steps(12);
        chk("holdoff_trig_count", 64'(trig_count), 64'd2);
        chk("holdoff_miss_count", 64'(miss_count), 64'd2);

        // Oneshot: second trigger ignored until re-armed.
        set_cfg(3, 2, 1, 1'b1);
        fire();
        steps(19);
        saved_trig = int'(trig_count);
        fire();
        steps(5);
        chk("oneshot_second_ignored", 64'(trig_count), 64'(saved_trig));
        arm = 1'b0;
        step();
        arm = 1'b1;
        steps(2);
        oneshot = 1'b0;
        fire();
        steps(12);

        // arm dropped mid-delay discards the trigger.
        set_cfg(100, 3, 0, 1'b0);
        fire();
        saved_trig = int'(trig_count);
        steps(10);
        arm = 1'b0;
        step();
        arm = 1'b1;
        steps(3);
        chk("abort_trig_count", 64'(trig_count), 64'(saved_trig));

        // rst mid-pulse drops trig_out without a clock edge.
        set_cfg(3, 10, 0, 1'b0);
        fire();
        steps(5);
        chk("pre_rst_trig_out", 64'(trig_out), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_trig_out", 64'(trig_out), 64'd0);
        model_reset();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_armed", 64'(armed), 64'd0);
        steps(3);

        // Maximum delay, pulse and holdoff.
        set_cfg(255, 15, 255, 1'b0);
        fire();
        steps(528);
        fire();
        steps(3);
        arm = 1'b0;
        step();
        arm = 1'b1;
        steps(2);

        // Miss counter saturation, then clear coinciding with a miss.
        set_cfg(255, 1, 0, 1'b0);
        fire();
        trig_in = 1'b1;
        steps(40);
        chk("miss_saturated", 64'(miss_count), 64'(c_cnt_max));
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        trig_in   = 1'b0;
        chk("miss_cleared", 64'(miss_count), 64'd0);
        arm = 1'b0;
        step();
        arm = 1'b1;
        steps(2);

        // Randomized traffic with settings changing every cycle.
        for (int i = 0; i < 3000; i++) begin
            if (arm_low_left > 0) begin
                arm = 1'b0;
                arm_low_left--;
            end else if ($urandom_range(0, 63) == 0) begin
                arm          = 1'b0;
                arm_low_left = $urandom_range(0, 2);
            end else begin
                arm = 1'b1;
            end
            trig_in     = ($urandom_range(0, 5) == 0);
            oneshot     = ($urandom_range(0, 9) == 0);
            clear_cnt   = ($urandom_range(0, 99) == 0);
            delay       = DLY_W'($urandom_range(0, 6));
            pulse_width = PW_W'($urandom_range(0, 4));
            holdoff     = DLY_W'($urandom_range(0, 3));
            step();
        end

        trig_in   = 1'b0;
        clear_cnt = 1'b0;
        arm       = 1'b0;
        steps(4);
        chk("no_pending_pulses", 64'(q_start.size()), 64'd0);
        chk("final_trig_out", 64'(trig_out), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trigger_pulse_shaper.md
TRIGGER_PULSE_SHAPER -- requirements
Module: trigger_pulse_shaper

Interface
REQ-001 Parameters SHALL be: DLY_W, default 32, width of delay/holdoff counters; PW_W, default 16, width of pulse-width counter; CNT_W, default 16, width of statistics counters.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 trig_in  input  1  one-cycle match pulse from the I/O pattern trigger stage.
REQ-005 arm  input  1  level; 1 enables trigger acceptance.
REQ-006 oneshot  input  1  level; 1 = accept one trigger per arm assertion.
REQ-007 delay  input  DLY_W  cycles from accepted trig_in to trig_out rise.
REQ-008 pulse_width  input  PW_W  trig_out high time in cycles; 0 treated as 1.
REQ-009 holdoff  input  DLY_W  dead cycles after pulse before re-acceptance.
REQ-010 clear_cnt  input  1  synchronous clear of both statistics counters.
REQ-011 trig_out  output  1  registered shaped trigger to capture/glitch logic.
REQ-012 armed  output  1  registered; 1 only in state ARMED.
REQ-013 busy  output  1  registered; 1 in DELAY, PULSE or HOLDOFF.
REQ-014 trig_count  output  CNT_W  accepted triggers, saturating.
REQ-015 miss_count  output  CNT_W  trig_in pulses ignored while busy, saturating.

Function
REQ-016 FSM states SHALL be IDLE, ARMED, DELAY, PULSE, HOLDOFF, DONE.
REQ-017 IDLE: arm=1 -> ARMED next cycle; trig_in ignored and not counted.
REQ-018 ARMED: trig_in=1 SHALL accept trigger: latch delay, pulse_width, holdoff; trig_count+1; go DELAY if delay>0 else PULSE.
REQ-019 Accepted trig_in sampled at edge t: trig_out SHALL be 1 in cycles t+1+D .. t+D+W, D=latched delay, W=max(pulse_width,1); 0 otherwise.
REQ-020 HOLDOFF SHALL span cycles t+D+W+1 .. t+D+W+H (H=latched holdoff; H=0 skips state).
REQ-021 After HOLDOFF (or PULSE if H=0): oneshot=0 -> ARMED, trig_in accepted at edge t+D+W+H+1 onward; oneshot=1 -> DONE.
REQ-022 DONE: trig_in ignored and not counted; arm=0 -> IDLE.
REQ-023 arm=0 in any state SHALL force IDLE next edge; trig_out SHALL be 0 from that edge; in-flight trigger discarded, trig_count unchanged.
REQ-024 trig_in=1 in DELAY, PULSE or HOLDOFF SHALL increment miss_count and not affect timing.
REQ-025 Changes to delay/pulse_width/holdoff/oneshot after acceptance SHALL NOT affect the trigger in flight (oneshot sampled at HOLDOFF/PULSE exit).
REQ-026 Counters SHALL saturate at all-ones, never wrap.
REQ-027 clear_cnt=1 SHALL zero both counters next edge; clear wins over simultaneous increment.
REQ-028 Max delay/holdoff = 2^DLY_W-1 cycles and max pulse = 2^PW_W-1 cycles, exact, no off-by-one.
REQ-029 arm rising and trig_in in same cycle while IDLE: trigger NOT accepted.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, trig_out=0, armed=0, busy=0, trig_count=0, miss_count=0, latched settings=0.
REQ-031 rst asserted mid-DELAY/PULSE SHALL drop trig_out asynchronously; after release block stays IDLE until arm seen high on a clock edge.

Verification
REQ-032 arm=1, oneshot=0, delay=5, pulse_width=3, holdoff=0, trig_in at edge t -> trig_out high cycles t+6..t+8, trig_count=1.
REQ-033 delay=0, pulse_width=0 -> trig_out high only cycle t+1.
REQ-034 delay=2, pulse_width=2, holdoff=4, trig_in at t, t+3, t+8, t+9 -> t, t+9 accepted; t+3, t+8 missed: trig_count=2, miss_count=2.
REQ-035 oneshot=1, two trig_in 20 cycles apart -> one pulse, DONE; arm 0 then 1 -> next trig_in accepted.
REQ-036 arm dropped during DELAY (delay=100) -> no trig_out pulse, IDLE, trig_count still 1; rst mid-PULSE -> trig_out 0 without clock edge.
REQ-037 miss_count preset to all-ones via 2^CNT_W misses, plus clear_cnt coinciding with miss -> saturates at all-ones, then reads 0 after clear.
